// File: rtl/serial_rx_package.sv
// ---------------------------------------------------------------------------
// serial_rx_package
//
// Single-clock UART package receiver. Deserializes 8N1 frames (or 8E1 when
// SERIAL_RX_PARITY_EN is defined) from the serial line and collects
// 2^AddressWidth words into one parallel package. The first word received
// lands in the most-significant slot, which matches the word order of the
// package transmitter. A completed package is published atomically together
// with a one-cycle valid strobe.
//
// Optional feature macro: SERIAL_RX_PARITY_EN
//   defined     : one even-parity bit follows the data bits. A mismatch is
//                 rejected exactly like a bad stop bit.
//   not defined : plain 8N1 framing.
//
// Parameters
//   AddressWidth     log2 of words per package
//   WordWidth        data bits per frame
//   SerialTimerWidth width of the bit-timing counter
//   ClocksPerBit     clk cycles per serial bit (even, >= 4, < 2^SerialTimerWidth)
//
// Ports
//   clk        in   the one clock, rising edge
//   rst        in   synchronous active-high reset
//   ce         in   receive enable, only looked at while idle
//   rx         in   serial line, idle high, asynchronous to clk
//   data       out  last completed package (word 0 in the MSB slot)
//   valid      out  one-cycle pulse on the edge where data updates
//   busy       out  a frame or a partial package is in progress
//   frameError out  one-cycle pulse when a frame is rejected
// ---------------------------------------------------------------------------
module serial_rx_package #(
    parameter int AddressWidth     = 2,
    parameter int WordWidth        = 8,
    parameter int SerialTimerWidth = 8,
    parameter int ClocksPerBit     = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     ce,
    input  logic                                     rx,
    output logic [WordWidth*(2**AddressWidth)-1:0]   data,
    output logic                                     valid,
    output logic                                     busy,
    output logic                                     frameError
);

    localparam int Words         = 2 ** AddressWidth;
    localparam int PackageWidth  = WordWidth * Words;
    localparam int BitIndexWidth = (WordWidth > 1) ? $clog2(WordWidth) : 1;

    localparam logic [SerialTimerWidth-1:0] HalfBitLoad  = SerialTimerWidth'(ClocksPerBit / 2 - 1);
    localparam logic [SerialTimerWidth-1:0] FullBitLoad  = SerialTimerWidth'(ClocksPerBit - 1);
    localparam logic [SerialTimerWidth-1:0] TimerZero    = {SerialTimerWidth{1'b0}};
    localparam logic [BitIndexWidth-1:0]    LastBitIndex = BitIndexWidth'(WordWidth - 1);
    localparam logic [AddressWidth-1:0]     LastWord     = {AddressWidth{1'b1}};
    localparam logic [AddressWidth-1:0]     FirstWord    = {AddressWidth{1'b0}};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef SERIAL_RX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

`ifdef SERIAL_RX_PARITY_EN
    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic evenParity(input logic [WordWidth-1:0] word);
        return ^word;
    endfunction
`endif

    // Two-flop synchronizer; reset to the idle-high line level so reset
    // release never looks like a start bit.
    logic [1:0] rxSync_r;
    logic       rxs_s;

    // Registered state
    state_t                      state_r;
    logic [SerialTimerWidth-1:0] timer_r;
    logic [BitIndexWidth-1:0]    bitIndex_r;
    logic [WordWidth-1:0]        shift_r;
    logic [AddressWidth-1:0]     wordIndex_r;
    logic [PackageWidth-1:0]     shadow_r;
    logic [PackageWidth-1:0]     data_r;
    logic                        valid_r;
    logic                        busy_r;
    logic                        frameError_r;
`ifdef SERIAL_RX_PARITY_EN
    logic                        parityError_r;
    logic                        nextParityError_s;
`endif

    // Next-state values
    state_t                      nextState_s;
    logic [SerialTimerWidth-1:0] nextTimer_s;
    logic [BitIndexWidth-1:0]    nextBitIndex_s;
    logic [WordWidth-1:0]        nextShift_s;
    logic [AddressWidth-1:0]     nextWordIndex_s;
    logic [PackageWidth-1:0]     nextShadow_s;
    logic [PackageWidth-1:0]     nextData_s;
    logic                        nextValid_s;
    logic                        nextBusy_s;
    logic                        nextFrameError_s;
    logic                        timerDone_s;
    logic                        frameOk_s;

    assign rxs_s       = rxSync_r[1];
    assign timerDone_s = (timer_r == TimerZero);

    // A frame is kept only if the stop bit is high (and parity matched).
`ifdef SERIAL_RX_PARITY_EN
    assign frameOk_s = rxs_s & ~parityError_r;
`else
    assign frameOk_s = rxs_s;
`endif

    assign data       = data_r;
    assign valid      = valid_r;
    assign busy       = busy_r;
    assign frameError = frameError_r;

    // Synchronize the asynchronous serial line into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxSync_r <= 2'b11;
        end else begin
            rxSync_r <= {rxSync_r[0], rx};
        end
    end

    // Receiver FSM next-state, datapath and output-strobe logic.
    always_comb begin
        nextState_s      = state_r;
        nextTimer_s      = timer_r;
        nextBitIndex_s   = bitIndex_r;
        nextShift_s      = shift_r;
        nextWordIndex_s  = wordIndex_r;
        nextShadow_s     = shadow_r;
        nextData_s       = data_r;
        nextValid_s      = 1'b0;
        nextFrameError_s = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        nextParityError_s = parityError_r;
`endif

        case (state_r)
            IDLE: begin
                if (ce && !rxs_s) begin
                    nextState_s = START;
                    nextTimer_s = HalfBitLoad;
                end else begin
                    nextState_s = IDLE;
                end
            end

            START: begin
                if (timerDone_s) begin
                    if (!rxs_s) begin
                        nextState_s    = DATA;
                        nextTimer_s    = FullBitLoad;
                        nextBitIndex_s = {BitIndexWidth{1'b0}};
                        nextShift_s    = {WordWidth{1'b0}};
`ifdef SERIAL_RX_PARITY_EN
                        nextParityError_s = 1'b0;
`endif
                    end else begin
                        // Line went back high by mid-bit: a glitch, not a start bit.
                        nextState_s = IDLE;
                    end
                end else begin
                    nextTimer_s = timer_r - SerialTimerWidth'(1);
                end
            end

            DATA: begin
                if (timerDone_s) begin
                    // LSB first: shift in at the top so bit 0 ends at the bottom.
                    nextShift_s = {rxs_s, shift_r[WordWidth-1:1]};
                    nextTimer_s = FullBitLoad;
                    if (bitIndex_r == LastBitIndex) begin
`ifdef SERIAL_RX_PARITY_EN
                        nextState_s = PARITY;
`else
                        nextState_s = STOP;
`endif
                    end else begin
                        nextBitIndex_s = bitIndex_r + BitIndexWidth'(1);
                    end
                end else begin
                    nextTimer_s = timer_r - SerialTimerWidth'(1);
                end
            end

`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                // Remember a mismatch and reject at the stop sample so the
                // frame keeps its full length on the line.
                if (timerDone_s) begin
                    nextParityError_s = (rxs_s != evenParity(shift_r));
                    nextTimer_s       = FullBitLoad;
                    nextState_s       = STOP;
                end else begin
                    nextTimer_s = timer_r - SerialTimerWidth'(1);
                end
            end
`endif

            STOP: begin
                if (timerDone_s) begin
                    nextState_s = IDLE;
                    if (frameOk_s) begin
                        for (int i = 0; i < Words; i++) begin
                            nextShadow_s[(Words-1-i)*WordWidth +: WordWidth] =
                                (wordIndex_r == AddressWidth'(i)) ? shift_r
                                                                  : shadow_r[(Words-1-i)*WordWidth +: WordWidth];
                        end
                        if (wordIndex_r == LastWord) begin
                            nextData_s      = nextShadow_s;
                            nextValid_s     = 1'b1;
                            nextWordIndex_s = FirstWord;
                        end else begin
                            nextWordIndex_s = wordIndex_r + AddressWidth'(1);
                        end
                    end else begin
                        nextFrameError_s = 1'b1;
                        nextWordIndex_s  = FirstWord;
                        nextShadow_s     = {PackageWidth{1'b0}};
                    end
                end else begin
                    nextTimer_s = timer_r - SerialTimerWidth'(1);
                end
            end

            default: begin
                nextState_s = IDLE;
            end
        endcase

        // Computed from next values so the registered busy lines up with state.
        nextBusy_s = (nextState_s != IDLE) || (nextWordIndex_s != FirstWord);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            timer_r      <= TimerZero;
            bitIndex_r   <= {BitIndexWidth{1'b0}};
            shift_r      <= {WordWidth{1'b0}};
            wordIndex_r  <= FirstWord;
            shadow_r     <= {PackageWidth{1'b0}};
            data_r       <= {PackageWidth{1'b0}};
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            frameError_r <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parityError_r <= 1'b0;
`endif
        end else begin
            state_r      <= nextState_s;
            timer_r      <= nextTimer_s;
            bitIndex_r   <= nextBitIndex_s;
            shift_r      <= nextShift_s;
            wordIndex_r  <= nextWordIndex_s;
            shadow_r     <= nextShadow_s;
            data_r       <= nextData_s;
            valid_r      <= nextValid_s;
            busy_r       <= nextBusy_s;
            frameError_r <= nextFrameError_s;
`ifdef SERIAL_RX_PARITY_EN
            parityError_r <= nextParityError_s;
`endif
        end
    end

endmodule

// File: doc/serial_rx_package.md
# serial_rx_package

Single-clock UART package receiver: deserializes 8N1 frames from a serial line and assembles `2^AddressWidth` words into one parallel package (for example, an image load for the morphologic processor). It is the receive counterpart of the package transmitter used by the image debug path, and uses the same word order. A completed package is presented atomically with a one-cycle `valid` strobe.

## Interface
- `AddressWidth`, 2: log2 of words per package (4 words).
- `WordWidth`, 8: data bits per frame.
- `SerialTimerWidth`, 8: width of the bit-timing counter.
- `ClocksPerBit`, 16: `clk` cycles per serial bit. Must be even, ≥4, and < 2^SerialTimerWidth.

- `clk`, in, 1: the one clock; all logic on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `ce`, in, 1: receive enable, sampled only in IDLE.
- `rx`, in, 1: serial line, idle high, asynchronous to `clk`.
- `data`, out, `WordWidth*2^AddressWidth`: last completed package; the first received word is in the most-significant slot.
- `valid`, out, 1: one-cycle pulse when `data` updates.
- `busy`, out, 1: a package is in progress.
- `frameError`, out, 1: one-cycle pulse when a frame is rejected.

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM sees only the synchronized `rxs`.
- FSM states: IDLE, START, DATA, (PARITY), STOP.
- IDLE: if `ce`=1 and `rxs`=0, go to START and load the timer with `ClocksPerBit/2-1`.
- START: when the timer reaches 0, re-sample `rxs`.
  - `rxs`=0: go to DATA, bit index 0, reload timer with `ClocksPerBit-1`.
  - `rxs`=1: glitch; return to IDLE with no error and word index unchanged.
- DATA: at each timer expiry, shift `rxs` in LSB-first. After `WordWidth` bits go to STOP (or PARITY, see Configuration).
- STOP: at expiry, sample `rxs`.
  - 1: write the word into the shadow buffer slot `wordIndex` (slot 0 = MSB) and increment `wordIndex`.
  - 0: pulse `frameError`, clear `wordIndex`, discard the partial package.
  - Return to IDLE in both cases.
- When the word at index `2^AddressWidth-1` is accepted: copy the shadow buffer to `data`, pulse `valid`, wrap `wordIndex` to 0.
- `data` holds its value until the next complete package; partial packages never alter it.
- `busy` = (state≠IDLE) or (`wordIndex`≠0).
- No inter-word timeout: a partial package waits indefinitely and is cleared only by a frame error or `rst`.
- `ce` deasserted mid-frame or mid-package does not abort. The current frame completes, and the next start bit is ignored until `ce`=1.

## Timing
- Reset values: `data`=0, `valid`=0, `busy`=0, `frameError`=0, state IDLE, `wordIndex`=0, shadow buffer 0.
- `rst` mid-frame or mid-package abandons all progress. The next falling edge after `rst` deasserts starts a new package at word 0.
- Let t0 be the `clk` edge where raw `rx` is first seen low. `rxs` falls at t0+2.
- START check occurs at t0+2+`ClocksPerBit/2`; data bit k is sampled `(k+1)*ClocksPerBit` later.
- Stop sample occurs at t0+2+`ClocksPerBit/2`+(`WordWidth`+1)*`ClocksPerBit` (+`ClocksPerBit` with parity).
- `valid`/`frameError` are registered and high on the cycle after the stop sample.
- `data` changes on the same edge that `valid` rises.
- The FSM returns to IDLE in the cycle after the stop sample. Back-to-back frames with zero extra idle time are accepted.

## Configuration
- `SERIAL_RX_PARITY_EN` defined:
  - A PARITY state follows DATA and samples one even-parity bit.
  - On mismatch, the frame is handled exactly like a stop-bit error: `frameError` pulse, `wordIndex` cleared.
  - Frame length becomes `WordWidth`+3 bits.
- Not defined: no parity bit; 8N1 framing.

## Test plan
- Defaults: send frames 0x00, 0x30, 0x18, 0x00 → `data`=32'h00301800, `valid` high for exactly 1 cycle after the 4th stop sample, `busy` falls the same cycle.
- `rx` low for 4 cycles, then high → no START acceptance, `busy`=0, no `frameError`, `wordIndex` still 0.
- 2nd frame sent with stop bit 0 → `frameError` pulse, no `valid`, `data` unchanged; a following clean 4-frame package 0xA5, 0x5A, 0xFF, 0x01 → `data`=32'hA55AFF01.
- Assert `rst` for 1 cycle after 2 frames → all outputs 0; the next 4 frames alone form the package and `valid` pulses once.
- `ce`=0 while a frame 0x55 arrives in IDLE → ignored, `busy` stays 0; `ce`=1 then 4 frames → normal package.
- With `SERIAL_RX_PARITY_EN`: frame 0x03 with parity bit 1 → `frameError`; the same frame with parity bit 0 → accepted.
